// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, branch funct3 codes, ALU and
// immediate selectors, the control bundle carried down the pipe and the
// ID/EX register layout.
package riscv_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_e;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_e;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_e;

  // a_sel_pc: ALU operand A is the pc (AUIPC). is_jalr: EX computes the target.
  typedef struct packed {
    alu_op_e    alu_op;
    logic       alu_src;
    logic       a_sel_pc;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    wb_sel_e    wb_sel;
    logic       is_branch;
    logic       is_jal;
    logic       is_jalr;
    logic [2:0] funct3;
  } ctrl_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    ctrl_t           ctrl;
  } id_ex_reg_t;

  localparam ctrl_t CTRL_NOP = '{
    alu_op: ALU_ADD, alu_src: 1'b0, a_sel_pc: 1'b0, mem_read: 1'b0,
    mem_write: 1'b0, reg_write: 1'b0, wb_sel: WB_ALU, is_branch: 1'b0,
    is_jal: 1'b0, is_jalr: 1'b0, funct3: 3'b000
  };

  localparam id_ex_reg_t ID_EX_BUBBLE = '{
    valid: 1'b0, pc: '0, rs1_data: '0, rs2_data: '0, imm: '0,
    rs1: '0, rs2: '0, rd: '0, ctrl: CTRL_NOP
  };

  // alt selects SUB/SRA; the caller decides when instr[30] is meaningful.
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/reg_file.sv
// Architectural register file, 2 read / 1 write.
//   clk, rst      : clock, synchronous active-high reset (clears all regs)
//   ra1/ra2       : read addresses, rd1/rd2 combinational read data
//   we/wa/wd      : write port, committed on the rising edge
// x0 always reads zero and ignores writes. A read of the register being
// written this cycle returns the write data (write-through).
module reg_file
  import riscv_pkg::*;
#(
  parameter int W  = XLEN,
  parameter int N  = NREGS,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [W-1:0]  rd1,
  output logic [W-1:0]  rd2,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0]  wd
);

  logic [W-1:0] regs [N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) regs[i] <= '0;
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : ((we && (wa == ra1)) ? wd : regs[ra1]);
  assign rd2 = (ra2 == '0) ? '0 : ((we && (wa == ra2)) ? wd : regs[ra2]);

endmodule

// File: rtl/decode_stage.sv
// ID stage of the 5-stage RV32I pipeline.
// Inputs : IF/ID register (id_valid, id_pc, id_instr, id_bp_state,
//          id_pred_taken), write-back port (wb_*), EX/MEM forward (mem_fwd_*).
// Outputs: PC / IF-ID control (pc_write_en, write_if_id, flush_if_id),
//          fetch redirect (redirect_valid, redirect_pc), predictor update
//          (branch_update_en, branch_taken_actual, resolved_*), and the
//          ID/EX pipeline register (id_ex, layout id_ex_reg_t).
// Conditional branches and JAL resolve here; JALR is resolved in EX.
module decode_stage
  import riscv_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          id_valid,
  input  logic [XLEN-1:0]               id_pc,
  input  logic [31:0]                   id_instr,
  input  logic [1:0]                    id_bp_state,
  input  logic                          id_pred_taken,
  input  logic                          wb_en,
  input  logic [4:0]                    wb_rd,
  input  logic [XLEN-1:0]               wb_data,
  input  logic                          mem_fwd_en,
  input  logic [4:0]                    mem_fwd_rd,
  input  logic [XLEN-1:0]               mem_fwd_data,
  output logic                          pc_write_en,
  output logic                          write_if_id,
  output logic                          flush_if_id,
  output logic                          redirect_valid,
  output logic [XLEN-1:0]               redirect_pc,
  output logic                          branch_update_en,
  output logic                          branch_taken_actual,
  output logic [XLEN-1:0]               resolved_pc,
  output logic [XLEN-1:0]               resolved_target,
  output logic [1:0]                    resolved_state,
  output logic [$bits(id_ex_reg_t)-1:0] id_ex
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  ctrl_t           ctrl;
  imm_sel_e        imm_sel;
  logic            use_rs1, use_rs2, use_rd;
  logic [4:0]      rs1, rs2, rd;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rf_rd1, rf_rd2, op_a, op_b;
  logic            br_cond, load_use, branch_hz, stall, resolve, taken, mispredict;
  logic            ex_match;
  id_ex_reg_t      id_ex_q, id_ex_d;
  // Destination of a load now in EX/MEM: its data is not forwardable until WB.
  logic [4:0]      mem_load_rd;

  assign opcode = id_instr[6:0];
  assign funct3 = id_instr[14:12];

  always_comb begin
    ctrl    = CTRL_NOP;
    imm_sel = IMM_NONE;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    ctrl.funct3 = funct3;
    case (opcode)
      OP_LUI: begin
        imm_sel = IMM_U; use_rd = 1'b1;
        ctrl.alu_op = ALU_PASS_B; ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1;
      end
      OP_AUIPC: begin
        imm_sel = IMM_U; use_rd = 1'b1;
        ctrl.alu_src = 1'b1; ctrl.a_sel_pc = 1'b1; ctrl.reg_write = 1'b1;
      end
      OP_JAL: begin
        imm_sel = IMM_J; use_rd = 1'b1;
        ctrl.is_jal = 1'b1; ctrl.reg_write = 1'b1; ctrl.wb_sel = WB_PC4;
      end
      OP_JALR: begin
        imm_sel = IMM_I; use_rs1 = 1'b1; use_rd = 1'b1;
        ctrl.alu_src = 1'b1; ctrl.is_jalr = 1'b1; ctrl.reg_write = 1'b1;
        ctrl.wb_sel = WB_PC4;
      end
      OP_BRANCH: begin
        imm_sel = IMM_B; use_rs1 = 1'b1; use_rs2 = 1'b1;
        ctrl.alu_op = ALU_SUB; ctrl.is_branch = 1'b1;
      end
      OP_LOAD: begin
        imm_sel = IMM_I; use_rs1 = 1'b1; use_rd = 1'b1;
        ctrl.alu_src = 1'b1; ctrl.mem_read = 1'b1; ctrl.reg_write = 1'b1;
        ctrl.wb_sel = WB_MEM;
      end
      OP_STORE: begin
        imm_sel = IMM_S; use_rs1 = 1'b1; use_rs2 = 1'b1;
        ctrl.alu_src = 1'b1; ctrl.mem_write = 1'b1;
      end
      OP_IMM: begin
        imm_sel = IMM_I; use_rs1 = 1'b1; use_rd = 1'b1;
        // instr[30] only distinguishes SRAI; for ADDI it is an immediate bit.
        ctrl.alu_op = alu_from_f3(funct3, id_instr[30] && (funct3 == 3'b101));
        ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1;
      end
      OP_REG: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
        ctrl.alu_op = alu_from_f3(funct3, id_instr[30]);
        ctrl.reg_write = 1'b1;
      end
      default: ;  // FENCE, SYSTEM and unknown opcodes travel as NOP control
    endcase
  end

  assign rs1 = use_rs1 ? id_instr[19:15] : 5'd0;
  assign rs2 = use_rs2 ? id_instr[24:20] : 5'd0;
  assign rd  = use_rd  ? id_instr[11:7]  : 5'd0;

  always_comb begin
    case (imm_sel)
      IMM_I:   imm = {{20{id_instr[31]}}, id_instr[31:20]};
      IMM_S:   imm = {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
      IMM_B:   imm = {{19{id_instr[31]}}, id_instr[31], id_instr[7],
                      id_instr[30:25], id_instr[11:8], 1'b0};
      IMM_U:   imm = {id_instr[31:12], 12'b0};
      IMM_J:   imm = {{11{id_instr[31]}}, id_instr[31], id_instr[19:12],
                      id_instr[20], id_instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  reg_file u_reg_file (
    .clk (clk),
    .rst (rst),
    .ra1 (rs1),
    .ra2 (rs2),
    .rd1 (rf_rd1),
    .rd2 (rf_rd2),
    .we  (wb_en),
    .wa  (wb_rd),
    .wd  (wb_data)
  );

  // EX/MEM forward beats the register file; WB priority over storage is
  // already provided by the register file write-through.
  always_comb begin
    op_a = rf_rd1;
    op_b = rf_rd2;
    if (mem_fwd_en && (mem_fwd_rd != 5'd0) && (mem_fwd_rd == rs1)) op_a = mem_fwd_data;
    if (mem_fwd_en && (mem_fwd_rd != 5'd0) && (mem_fwd_rd == rs2)) op_b = mem_fwd_data;
  end

  always_comb begin
    case (funct3)
      F3_BEQ:  br_cond = (op_a == op_b);
      F3_BNE:  br_cond = (op_a != op_b);
      F3_BLT:  br_cond = ($signed(op_a) <  $signed(op_b));
      F3_BGE:  br_cond = ($signed(op_a) >= $signed(op_b));
      F3_BLTU: br_cond = (op_a <  op_b);
      F3_BGEU: br_cond = (op_a >= op_b);
      default: br_cond = 1'b0;
    endcase
  end

  // Unused source fields are zero and rd must be nonzero, so x0 never matches.
  assign ex_match  = id_ex_q.valid && (id_ex_q.rd != 5'd0) &&
                     ((id_ex_q.rd == rs1) || (id_ex_q.rd == rs2));
  assign load_use  = id_valid && ex_match && id_ex_q.ctrl.mem_read;
  // A branch waits for any producer in ID/EX, and additionally for a load in
  // EX/MEM, giving two stall cycles behind a load.
  assign branch_hz = id_valid && ctrl.is_branch &&
                     ((ex_match && id_ex_q.ctrl.reg_write) ||
                      ((mem_load_rd != 5'd0) &&
                       ((mem_load_rd == rs1) || (mem_load_rd == rs2))));
  assign stall     = load_use || branch_hz;

  assign resolve    = id_valid && !stall && (ctrl.is_branch || ctrl.is_jal);
  assign taken      = resolve && (ctrl.is_jal || (ctrl.is_branch && br_cond));
  assign mispredict = resolve && (taken != id_pred_taken);

  assign pc_write_en         = !stall;
  assign write_if_id         = !stall;
  assign flush_if_id         = mispredict;
  assign redirect_valid      = mispredict;
  assign resolved_target     = id_pc + imm;
  assign redirect_pc         = taken ? resolved_target : (id_pc + 32'd4);
  assign branch_update_en    = resolve && ctrl.is_branch;
  assign branch_taken_actual = taken;
  assign resolved_pc         = id_pc;
  assign resolved_state      = id_bp_state;

  always_comb begin
    id_ex_d = ID_EX_BUBBLE;
    if (id_valid && !stall) begin
      id_ex_d.valid    = 1'b1;
      id_ex_d.pc       = id_pc;
      id_ex_d.rs1_data = rf_rd1;
      id_ex_d.rs2_data = rf_rd2;
      id_ex_d.imm      = imm;
      id_ex_d.rs1      = rs1;
      id_ex_d.rs2      = rs2;
      id_ex_d.rd       = rd;
      id_ex_d.ctrl     = ctrl;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex_q     <= ID_EX_BUBBLE;
      mem_load_rd <= 5'd0;
    end else begin
      id_ex_q     <= id_ex_d;
      mem_load_rd <= (id_ex_q.valid && id_ex_q.ctrl.mem_read) ? id_ex_q.rd : 5'd0;
    end
  end

  assign id_ex = id_ex_q;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
  import riscv_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, id_valid, id_pred_taken, wb_en, mem_fwd_en;
  logic [31:0] id_pc, id_instr, wb_data, mem_fwd_data;
  logic [1:0]  id_bp_state;
  logic [4:0]  wb_rd, mem_fwd_rd;
  logic        pc_write_en, write_if_id, flush_if_id, redirect_valid;
  logic        branch_update_en, branch_taken_actual;
  logic [31:0] redirect_pc, resolved_pc, resolved_target;
  logic [1:0]  resolved_state;
  logic [$bits(id_ex_reg_t)-1:0] id_ex;
  id_ex_reg_t  ie;

  assign ie = id_ex_reg_t'(id_ex);

  decode_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
    .id_bp_state(id_bp_state), .id_pred_taken(id_pred_taken),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .mem_fwd_en(mem_fwd_en), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .pc_write_en(pc_write_en), .write_if_id(write_if_id), .flush_if_id(flush_if_id),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .branch_update_en(branch_update_en), .branch_taken_actual(branch_taken_actual),
    .resolved_pc(resolved_pc), .resolved_target(resolved_target),
    .resolved_state(resolved_state), .id_ex(id_ex)
  );

  // ---------------- scoreboard ----------------
  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    id_valid = 1'b0; wb_en = 1'b0; mem_fwd_en = 1'b0;
    id_pred_taken = 1'b0;
  endtask

  task automatic idle();
    quiet();
    step();
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic pred, input logic [1:0] st);
    id_valid = 1'b1; id_instr = instr; id_pc = pc;
    id_pred_taken = pred; id_bp_state = st;
    #1;
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
    quiet();
    wb_en = 1'b1; wb_rd = r; wb_data = d;
    step();
    wb_en = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        pred;
    logic [1:0]  st;
    logic        e_taken;
    logic        e_upd;
    logic        e_redir;
    logic [31:0] e_rpc;
    logic [31:0] e_tgt;
    logic [31:0] e_imm;
    logic [4:0]  e_rd;
    logic [31:0] e_rs1d;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  initial begin
    // regs for the table: x1 = 7, x2 = 7, x3 = -5
    vecs[0]  = '{enc_b(13'h0010, 5'd2, 5'd1, 3'b000), 32'h100, 1'b0, 2'b01,
                 1'b1, 1'b1, 1'b1, 32'h110, 32'h110, 32'h10, 5'd0, 32'd7};
    vecs[1]  = '{enc_b(13'h1FF8, 5'd1, 5'd1, 3'b001), 32'h200, 1'b0, 2'b10,
                 1'b0, 1'b1, 1'b0, 32'h204, 32'h1F8, 32'hFFFF_FFF8, 5'd0, 32'd7};
    vecs[2]  = '{enc_b(13'h0020, 5'd1, 5'd3, 3'b100), 32'h300, 1'b1, 2'b11,
                 1'b1, 1'b1, 1'b0, 32'h320, 32'h320, 32'h20, 5'd0, 32'hFFFF_FFFB};
    vecs[3]  = '{enc_b(13'h0020, 5'd1, 5'd3, 3'b110), 32'h300, 1'b1, 2'b11,
                 1'b0, 1'b1, 1'b1, 32'h304, 32'h320, 32'h20, 5'd0, 32'hFFFF_FFFB};
    vecs[4]  = '{enc_b(13'h1FFC, 5'd3, 5'd1, 3'b101), 32'h400, 1'b0, 2'b00,
                 1'b1, 1'b1, 1'b1, 32'h3FC, 32'h3FC, 32'hFFFF_FFFC, 5'd0, 32'd7};
    vecs[5]  = '{enc_b(13'h0008, 5'd3, 5'd1, 3'b111), 32'h400, 1'b0, 2'b01,
                 1'b0, 1'b1, 1'b0, 32'h404, 32'h408, 32'h8, 5'd0, 32'd7};
    vecs[6]  = '{enc_j(21'h000800, 5'd9), 32'h1000, 1'b0, 2'b10,
                 1'b1, 1'b0, 1'b1, 32'h1800, 32'h1800, 32'h800, 5'd9, 32'd0};
    vecs[7]  = '{enc_i(12'hFFF, 5'd1, 3'b000, 5'd7, 7'b0010011), 32'h500, 1'b0, 2'b00,
                 1'b0, 1'b0, 1'b0, 32'h504, 32'h4FF, 32'hFFFF_FFFF, 5'd7, 32'd7};
    vecs[8]  = '{enc_s(12'h00C, 5'd2, 5'd1, 3'b010), 32'h600, 1'b0, 2'b00,
                 1'b0, 1'b0, 1'b0, 32'h604, 32'h60C, 32'hC, 5'd0, 32'd7};
    vecs[9]  = '{{20'h12345, 5'd8, 7'b0110111}, 32'h700, 1'b0, 2'b00,
                 1'b0, 1'b0, 1'b0, 32'h704, 32'h1234_5700, 32'h1234_5000, 5'd8, 32'd0};
    vecs[10] = '{enc_j(21'h000008, 5'd0), 32'hFFFF_FFFC, 1'b0, 2'b01,
                 1'b1, 1'b0, 1'b1, 32'h4, 32'h4, 32'h8, 5'd0, 32'd0};
  end

  // ---------------- test ----------------
  initial begin
    rst = 1'b1;
    id_instr = '0; id_pc = '0; id_bp_state = '0;
    wb_rd = '0; wb_data = '0; mem_fwd_rd = '0; mem_fwd_data = '0;
    quiet();
    step(); step();

    chk("reset id_ex.valid", ie.valid, 1'b0);
    chk("reset id_ex.rd", ie.rd, 5'd0);
    chk("reset pc_write_en", pc_write_en, 1'b1);
    chk("reset write_if_id", write_if_id, 1'b1);
    chk("reset flush", flush_if_id, 1'b0);
    chk("reset redirect", redirect_valid, 1'b0);
    chk("reset update_en", branch_update_en, 1'b0);
    rst = 1'b0;

    wb_write(5'd1, 32'd7);
    wb_write(5'd2, 32'd7);
    wb_write(5'd3, 32'hFFFF_FFFB);
    idle();

    // table-driven decode / resolution
    for (int k = 0; k < NV; k++) begin
      drive(vecs[k].instr, vecs[k].pc, vecs[k].pred, vecs[k].st);
      chk($sformatf("v%0d pc_write_en", k), pc_write_en, 1'b1);
      chk($sformatf("v%0d taken", k), branch_taken_actual, vecs[k].e_taken);
      chk($sformatf("v%0d update_en", k), branch_update_en, vecs[k].e_upd);
      chk($sformatf("v%0d redirect", k), redirect_valid, vecs[k].e_redir);
      chk($sformatf("v%0d flush", k), flush_if_id, vecs[k].e_redir);
      chk($sformatf("v%0d redirect_pc", k), redirect_pc, vecs[k].e_rpc);
      chk($sformatf("v%0d target", k), resolved_target, vecs[k].e_tgt);
      chk($sformatf("v%0d state", k), resolved_state, vecs[k].st);
      chk($sformatf("v%0d resolved_pc", k), resolved_pc, vecs[k].pc);
      step();
      chk($sformatf("v%0d id_ex.valid", k), ie.valid, 1'b1);
      chk($sformatf("v%0d id_ex.pc", k), ie.pc, vecs[k].pc);
      chk($sformatf("v%0d id_ex.imm", k), ie.imm, vecs[k].e_imm);
      chk($sformatf("v%0d id_ex.rd", k), ie.rd, vecs[k].e_rd);
      chk($sformatf("v%0d id_ex.rs1_data", k), ie.rs1_data, vecs[k].e_rs1d);
      idle();
    end

    // write-through, and x0 stays zero
    drive(enc_r(7'd0, 5'd0, 5'd5, 3'b000, 5'd6), 32'h40, 1'b0, 2'b00);
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
    step();
    chk("wt rs1_data", ie.rs1_data, 32'hDEAD_BEEF);
    chk("wt rs1", ie.rs1, 5'd5);
    chk("wt rd", ie.rd, 5'd6);
    drive(enc_r(7'd0, 5'd5, 5'd0, 3'b000, 5'd6), 32'h44, 1'b0, 2'b00);
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234_5678;
    step();
    chk("x0 write-through", ie.rs1_data, 32'd0);
    chk("x5 stored", ie.rs2_data, 32'hDEAD_BEEF);
    wb_en = 1'b0;
    drive(enc_r(7'd0, 5'd0, 5'd0, 3'b000, 5'd6), 32'h48, 1'b0, 2'b00);
    step();
    chk("x0 after write", ie.rs1_data, 32'd0);
    idle(); idle();

    // load-use: one bubble, then the consumer enters ID/EX
    drive(enc_i(12'h000, 5'd2, 3'b010, 5'd1, 7'b0000011), 32'h80, 1'b0, 2'b00);
    step();
    drive(enc_r(7'd0, 5'd1, 5'd1, 3'b000, 5'd3), 32'h84, 1'b0, 2'b00);
    chk("lu pc_write_en", pc_write_en, 1'b0);
    chk("lu write_if_id", write_if_id, 1'b0);
    step();
    chk("lu bubble", ie.valid, 1'b0);
    chk("lu released", pc_write_en, 1'b1);
    step();
    chk("lu add valid", ie.valid, 1'b1);
    chk("lu add rd", ie.rd, 5'd3);
    idle(); idle(); idle();

    // branch behind a load: two stalls, resolve with WB data
    drive(enc_i(12'h000, 5'd2, 3'b010, 5'd4, 7'b0000011), 32'h7FC, 1'b0, 2'b00);
    step();
    drive(enc_b(13'h000C, 5'd0, 5'd4, 3'b100), 32'h800, 1'b0, 2'b10);
    chk("bl stall1", pc_write_en, 1'b0);
    chk("bl stall1 update", branch_update_en, 1'b0);
    step();
    chk("bl stall2", pc_write_en, 1'b0);
    chk("bl stall2 update", branch_update_en, 1'b0);
    chk("bl stall2 redirect", redirect_valid, 1'b0);
    chk("bl stall2 bubble", ie.valid, 1'b0);
    step();
    wb_en = 1'b1; wb_rd = 5'd4; wb_data = 32'hFFFF_FFFF;
    #1;
    chk("bl go", pc_write_en, 1'b1);
    chk("bl update", branch_update_en, 1'b1);
    chk("blt -1<0 taken", branch_taken_actual, 1'b1);
    chk("bl redirect_pc", redirect_pc, 32'h80C);
    step();
    quiet();
    #1;
    chk("bl one pulse", branch_update_en, 1'b0);
    chk("bl in id_ex", ie.valid, 1'b1);
    drive(enc_b(13'h000C, 5'd0, 5'd4, 3'b110), 32'h900, 1'b1, 2'b11);
    chk("bltu no stall", pc_write_en, 1'b1);
    chk("bltu not taken", branch_taken_actual, 1'b0);
    chk("bltu redirect", redirect_valid, 1'b1);
    chk("bltu redirect_pc", redirect_pc, 32'h904);
    step();

    // operand priority: EX/MEM forward > WB > regfile (x4 = FFFFFFFF)
    drive(enc_b(13'h0010, 5'd0, 5'd4, 3'b000), 32'hA00, 1'b0, 2'b00);
    mem_fwd_en = 1'b1; mem_fwd_rd = 5'd4; mem_fwd_data = 32'd0;
    wb_en = 1'b1; wb_rd = 5'd4; wb_data = 32'd5;
    #1;
    chk("prio fwd over wb", branch_taken_actual, 1'b1);
    step();
    drive(enc_b(13'h0010, 5'd0, 5'd4, 3'b000), 32'hA10, 1'b0, 2'b00);
    mem_fwd_en = 1'b0; wb_en = 1'b1; wb_rd = 5'd4; wb_data = 32'd0;
    #1;
    chk("prio wb over rf", branch_taken_actual, 1'b1);
    step();
    idle(); idle();

    // ALU producer: a single stall, then EX/MEM forwarding
    drive(enc_r(7'd0, 5'd0, 5'd1, 3'b000, 5'd4), 32'hAFC, 1'b0, 2'b00);
    step();
    drive(enc_b(13'h0008, 5'd1, 5'd4, 3'b000), 32'hB00, 1'b0, 2'b00);
    chk("alu stall", pc_write_en, 1'b0);
    step();
    mem_fwd_en = 1'b1; mem_fwd_rd = 5'd4; mem_fwd_data = 32'd7;
    #1;
    chk("alu released", pc_write_en, 1'b1);
    chk("alu fwd taken", branch_taken_actual, 1'b1);
    idle(); idle(); idle();

    // reset during a load-use stall
    drive(enc_i(12'h000, 5'd2, 3'b010, 5'd1, 7'b0000011), 32'hC00, 1'b0, 2'b00);
    step();
    drive(enc_r(7'd0, 5'd1, 5'd1, 3'b000, 5'd3), 32'hC04, 1'b0, 2'b00);
    chk("rs stall", pc_write_en, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rs id_ex.valid", ie.valid, 1'b0);
    chk("rs pc_write_en", pc_write_en, 1'b1);
    for (int r = 1; r < 32; r++) begin
      logic [4:0] ra;
      ra = 5'(r);
      drive(enc_r(7'd0, 5'd0, ra, 3'b000, 5'd6), 32'hD00, 1'b0, 2'b00);
      step();
      chk($sformatf("rs x%0d zero", r), ie.rs1_data, 32'd0);
    end
    idle();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- ID stage of the 5-stage RV32I pipeline. Consumes the IF/ID register (pc, instruction, 2-bit predictor state, predicted-taken flag).
- Reads the 32x32 register file and decodes control and immediate. Resolves conditional branches and JAL in ID and returns the resolution to the branch predictor.
- Detects load-use and branch-operand hazards. Drives the PC/IF-ID write enables, the IF redirect and flush, and owns the ID/EX pipeline register.

Parameters:
XLEN, 32, datapath width
NREGS, 32, architectural registers (x0 hardwired zero)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
id_valid  in  1  IF/ID holds a real instruction
id_pc  in  32  IF/ID pc
id_instr  in  32  IF/ID instruction
id_bp_state  in  2  predictor counter state captured at fetch
id_pred_taken  in  1  fetch predicted taken
wb_en  in  1  write-back enable
wb_rd  in  5  write-back destination
wb_data  in  32  write-back value
mem_fwd_en  in  1  EX/MEM result valid for forwarding
mem_fwd_rd  in  5  EX/MEM destination
mem_fwd_data  in  32  EX/MEM ALU result
pc_write_en  out  1  PC register update enable
write_if_id  out  1  IF/ID register update enable
flush_if_id  out  1  load a bubble into IF/ID next edge
redirect_valid  out  1  overwrite next_pc with redirect_pc
redirect_pc  out  32  corrected fetch address
branch_update_en  out  1  predictor update strobe
branch_taken_actual  out  1  resolved direction
resolved_pc  out  32  pc of the resolved branch
resolved_target  out  32  pc + immediate
resolved_state  out  2  id_bp_state passthrough
id_ex  out  $bits(id_ex_reg_t)  ID/EX register: valid, pc, rs1/rs2 data, imm, rs1, rs2, rd, ctrl

Behaviour:
- Reset: id_ex cleared (valid=0, ctrl=NOP); regfile x1..x31 cleared. Comb outputs with no valid input: pc_write_en=1, write_if_id=1, flush/redirect/update=0.
- Decode: opcode selects ctrl_t fields: alu_op, alu_src, mem_read, mem_write, reg_write, wb_sel, is_branch, is_jal, funct3.
- Immediates: I/S/B/U/J, sign-extended to 32. Fields rs1/rs2/rd are zeroed when unused by the format.
- Regfile:
  - Two combinational reads, one write at the clock edge.
  - Writes to x0 are ignored.
  - Write-through: a read of wb_rd while wb_en returns wb_data same cycle (x0 excluded).
- Load-use stall: id_valid, id_ex.valid, id_ex.ctrl.mem_read, id_ex.rd!=0, and rd equal to a used rs1/rs2. Response:
  - pc_write_en=0, write_if_id=0.
  - id_ex loads a bubble (valid=0, ctrl=NOP).
  - Lasts 1 cycle.
- Branch-operand stall: a B-type instruction with a source equal to id_ex.rd (rd!=0, id_ex.ctrl.reg_write) stalls the same way. A load producer gives 2 cycles total.
- Branch operands: priority EX/MEM forward (mem_fwd_en, rd match, rd!=0) > WB write-through > regfile.
- Resolution (id_valid, not stalled):
  - B-type: compare per funct3 (BEQ, BNE, BLT, BGE, BLTU, BGEU).
  - JAL: taken.
  - resolved_target = id_pc + imm, mod 2^32 wraparound.
  - branch_update_en=1 for exactly one cycle per resolved instruction. Not asserted on JAL or during a stall.
- Mispredict: branch_taken_actual != id_pred_taken (JAL: id_pred_taken=0). Response:
  - redirect_valid=1, flush_if_id=1.
  - redirect_pc = taken ? resolved_target : id_pc+4.
  - The branch itself proceeds to ID/EX.
- Stall and mispredict in the same cycle: the stall wins and no resolution outputs are produced.
- flush_if_id together with write_if_id: flush wins and IF/ID becomes a bubble.
- id_valid=0: no stall, no resolution, id_ex gets a bubble.
- Normal operation: id_ex loads the decoded instruction every edge (latency 1).
- Reset asserted mid-stall: all state cleared next edge and the stall is dropped.
- JALR, FENCE, SYSTEM: pass through to EX; JALR is resolved in EX.

Decomposition:
- riscv_pkg holds: opcode constants, funct3 branch codes, alu_op_e, imm_sel_e, ctrl_t, id_ex_reg_t, CTRL_NOP.
- One sub-module, reg_file: 2R1W, synchronous reset, write-through, x0=0.
- Hazard, immediate and compare logic stay in decode_stage.

Test Plan:
1. Write-through: WB x5=0xDEAD_BEEF while "add x6,x5,x0" is in ID -> id_ex.rs1_data=0xDEADBEEF in the same cycle. A write to x0 leaves reads of x0 = 0.
2. Load-use: "lw x1,0(x2)" then "add x3,x1,x1" -> 1 cycle of pc_write_en=0, write_if_id=0, id_ex.valid=0; the add enters ID/EX on the next cycle.
3. Branch mispredict taken: x1=x2=7, "beq x1,x2,+16" at pc=0x100, id_pred_taken=0 -> branch_update_en=1, taken=1, resolved_target=0x110, redirect_pc=0x110, flush_if_id=1, resolved_state=id_bp_state.
4. Predicted correctly: "bne x1,x1,-8" at 0x200, id_pred_taken=0 -> update_en=1, taken=0, resolved_target=0x1F8, redirect_valid=0.
5. Branch dependency: "lw x4" then "blt x4,x0" -> 2 stall cycles. Resolution occurs on the 3rd cycle using mem_fwd/WB data and update_en pulses once. Signed vs unsigned checked with x4=0xFFFF_FFFF (BLT taken, BLTU not).
6. Reset asserted during a load-use stall -> next edge id_ex.valid=0, pc_write_en=1, all regs read 0. JAL at pc=0xFFFF_FFFC with imm=+8 -> resolved_target=0x0000_0004 (wraparound).
